// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for alu_share_arbiter.
//   state_t      : arbiter FSM states (IDLE, EXEC, RESP)
//   ALU_* consts : alucontrol encodings of the shared ALU
//   *_DEF        : default operand and control widths
package alu_share_arbiter_pkg;

   localparam int unsigned WIDTH_DEF = 32;
   localparam int unsigned CTRLW_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant, purely combinational.
// Ports:
//   valid      in  2  request valids
//   last_grant in  1  id of the most recent accepted requester
//   grant      out 2  one-hot grant, zero when nothing is valid
// The last_grant register lives in the parent.
module rr_arb2
   import alu_share_arbiter_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = '0;
      unique case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         // contention: favour whoever did not win last time
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = '0;
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant in IDLE, registered operands drive the ALU during EXEC,
// registered result/zero/owner are held in RESP until consumed.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready [1:0]       per-requester handshake (ready one-hot or zero)
//   req_a0/req_b0/req_ctrl0         requester 0 operands and op
//   req_a1/req_b1/req_ctrl1         requester 1 operands and op
//   alu_a/alu_b/alu_ctrl            registered operands to the ALU
//   alu_result/alu_zero             ALU outputs
//   rsp_valid/rsp_ready             response handshake
//   rsp_id/rsp_result/rsp_zero      registered response
// Build option: define ALU_ARB_BYPASS_EN to allow a new grant in RESP on the
// same cycle the response is consumed (1 op / 2 cycles instead of 1 op / 3).
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned CTRLW = CTRLW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [CTRLW-1:0] req_ctrl0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   input  logic [CTRLW-1:0] req_ctrl1,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [CTRLW-1:0] alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero
);

   state_t     state;
   state_t     state_next;
   logic       last_grant;
   logic [1:0] grant;
   logic       accept;
   logic       grant_id;

   rr_arb2 u_arb (
      .valid      (req_valid),
      .last_grant (last_grant),
      .grant      (grant)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      req_ready  = '0;
      unique case (state)
         ST_IDLE: begin
            req_ready = grant;
            if (grant != '0) state_next = ST_EXEC;
         end
         ST_EXEC: state_next = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) begin
`ifdef ALU_ARB_BYPASS_EN
               req_ready  = grant;
               state_next = (grant != '0) ? ST_EXEC : ST_IDLE;
`else
               state_next = ST_IDLE;
`endif
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign accept   = |req_ready;
   assign grant_id = req_ready[1];

   // Owner id is captured at accept; with bypass it may change in the same
   // edge that drops rsp_valid, so a visible response never sees it move.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_ctrl   <= '0;
         last_grant <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
      end else begin
         if (accept) begin
            alu_a      <= grant_id ? req_a1    : req_a0;
            alu_b      <= grant_id ? req_b1    : req_b0;
            alu_ctrl   <= grant_id ? req_ctrl1 : req_ctrl0;
            rsp_id     <= grant_id;
            last_grant <= grant_id;
         end
         if (state == ST_EXEC) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_valid  <= 1'b1;
         end else if (state == ST_RESP && rsp_ready) begin
            rsp_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance between two requesters, e.g. requester 0 = integer pipeline side-path and requester 1 = debug/CSR unit.
- Arbitration is round-robin. Each request uses a valid/ready handshake.
- Operands are registered before they reach the ALU. Results are registered and returned with the owner ID.
- Sits between the requesters and the ALU's a/b/alucontrol inputs and result/zero outputs.

Parameters:
- WIDTH, 32, operand/result width.
- CTRLW, 3, alucontrol width. Encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept (one-hot or zero)
- req_a0, req_b0  in  WIDTH  requester 0 operands
- req_ctrl0  in  CTRLW  requester 0 op
- req_a1, req_b1  in  WIDTH  requester 1 operands
- req_ctrl1  in  CTRLW  requester 1 op
- alu_a, alu_b  out  WIDTH  to ALU a/b
- alu_ctrl  out  CTRLW  to ALU alucontrol
- alu_result  in  WIDTH  from ALU result
- alu_zero  in  1  from ALU zero
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_id  out  1  owner of response
- rsp_result  out  WIDTH  registered result
- rsp_zero  out  1  registered zero flag

Behaviour:
- Single clock. reset is synchronous and active-high. All state is sampled on posedge clk.
- Reset values:
  - state = IDLE
  - alu_a, alu_b, alu_ctrl = 0
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_zero = 0
  - last_grant = 1, so requester 0 wins first.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational and asserted only for the granted requester.
  - Grant rules:
    - Only one valid: that requester is granted.
    - Both valid: the requester ≠ last_grant is granted.
    - None valid: req_ready = 0.
  - On grant, at the clock edge: latch that requester's a/b/ctrl into the alu_a/alu_b/alu_ctrl registers, latch the id, set last_grant = id, and go to EXEC.
- EXEC (exactly 1 cycle):
  - The ALU sees the registered operands.
  - At the edge: rsp_result <= alu_result, rsp_zero <= alu_zero, rsp_valid <= 1, go to RESP.
  - req_ready = 0.
- RESP:
  - rsp_valid, rsp_id, rsp_result and rsp_zero are held stable until rsp_ready = 1.
  - On rsp_ready: rsp_valid <= 0 and go to IDLE.
  - req_ready = 0.
- Latency: accept edge → rsp_valid high 2 edges later. Throughput is 1 op per 3 cycles when rsp_ready is tied high.
- Operand registers hold their last values after completion; they are not cleared.
- Requester rules:
  - A requester must hold valid and its operands stable until accepted.
  - Deasserting valid before accept is legal; no grant occurs for it.
  - last_grant is updated only on an actual accept.
- reset has priority over every other event. Reset asserted in EXEC or RESP drops the in-flight op (rsp_valid = 0 next cycle, no response issued).
- ALU arithmetic, overflow and slt behaviour belong to the ALU. This block does not alter or inspect any result.

Optional Feature:
- ALU_ARB_BYPASS_EN defined:
  - In RESP with rsp_ready = 1, the arbiter also evaluates grant the same cycle.
  - On a grant it latches the new operands, clears rsp_valid and goes directly to EXEC.
  - Throughput becomes 1 op per 2 cycles. req_ready may be asserted in RESP only when rsp_ready = 1.
- Undefined: behaviour exactly as above. RESP always returns to IDLE.

Decomposition:
- Shared package:
  - state enum (IDLE, EXEC, RESP)
  - ALU op constants (ALU_ADD … ALU_SRL)
  - WIDTH/CTRLW defaults
- One natural sub-module: rr_arb2, a 2-way round-robin grant taking valid[1:0] and last_grant and returning one-hot grant[1:0]. Pure combinational. last_grant is held in the parent.

Test Plan:
- Reset, then only req_valid = 01 with a0 = 5, b0 = 3, ctrl0 = 000 → req_ready = 01 for 1 cycle; 2 edges later rsp_valid = 1, rsp_id = 0, rsp_result = 8, rsp_zero = 0.
- Both valid continuously, rsp_ready = 1: req0 sub 7−7, req1 xor F0^0F → grants alternate 0, 1, 0…; responses are 0 (zero = 1) and 0xFF (zero = 0).
- rsp_ready = 0 for 5 cycles while in RESP → rsp_* stable, req_ready = 00 despite req_valid = 11; releasing rsp_ready → IDLE, next grant goes to the other requester.
- req1 slt with a = 0xFFFFFFFF, b = 1 → rsp_result = 1, rsp_id = 1; then req1 sll with a = 1, b = 31 → rsp_result = 0x80000000.
- Reset asserted in EXEC → next cycle state IDLE, rsp_valid = 0, last_grant = 1; no response ever appears for the dropped op.
- With ALU_ARB_BYPASS_EN: back-to-back req0 ops, rsp_ready = 1 → rsp_valid pulses every 2 cycles. Without it, every 3 cycles.
